// File: rtl/wts_channel_array.sv
// wts_channel_array: round-robin tone/noise channel engine; define WTS_NOISE_GATE_EN to build LFSR noise gating
module wts_channel_array #(
  parameter int CH_NUM = 5,
  parameter int ADDR_W = 7,
  parameter int FREQ_W = 12,
  parameter int ENV_W  = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic [CH_NUM-1:0]            address_reset,
  input  logic [CH_NUM*FREQ_W-1:0]     reg_frequency_count,
  input  logic [CH_NUM*2-1:0]          reg_wave_length,
  input  logic [CH_NUM-1:0]            reg_noise_enable,
  input  logic [4:0]                   reg_noise_frequency_count,
  input  logic [CH_NUM*ENV_W-1:0]      envelope_in,
  output logic                         out_valid,
  output logic [$clog2(CH_NUM)-1:0]    out_ch,
  output logic [ADDR_W-1:0]            sram_a,
  output logic [ENV_W-1:0]             envelope
);
  localparam int CW = $clog2(CH_NUM);
  localparam logic [ADDR_W-1:0] ONES = '1;
  logic [CW-1:0] ch_sel_q, ch_sel_d;
  logic [FREQ_W-1:0] cnt_q [CH_NUM];
  logic [FREQ_W-1:0] cnt_d [CH_NUM];
  logic [ADDR_W-1:0] addr_q [CH_NUM];
  logic [ADDR_W-1:0] addr_d [CH_NUM];
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [FREQ_W-1:0] freq;
  logic [1:0] wl;
  logic [ADDR_W-1:0] mask, addr_m, addr_nx;
  logic [ENV_W-1:0] env_in, env_g;
  int c;
  always_comb begin
    c = int'(ch_sel_q);
    freq = reg_frequency_count[c*FREQ_W +: FREQ_W];
    wl = reg_wave_length[c*2 +: 2];
    mask = wl[1] ? ONES : wl[0] ? ONES >> 1 : ONES >> 2;
    addr_m = addr_q[ch_sel_q] & mask;
    env_in = envelope_in[c*ENV_W +: ENV_W];
    cnt_d = cnt_q;
    addr_d = addr_q;
    pend_d = pend_q | address_reset;
    ch_sel_d = ch_sel_q;
    addr_nx = addr_m;
    if (active) begin
      ch_sel_d = (ch_sel_q == CW'(CH_NUM - 1)) ? '0 : ch_sel_q + 1'b1;
      // a reset pulse landing in the service cycle is already folded into pend_d
      if (pend_d[ch_sel_q]) begin
        addr_nx = '0;
        addr_d[ch_sel_q] = '0;
        cnt_d[ch_sel_q] = freq;
      end else if (cnt_q[ch_sel_q] == '0) begin
        addr_nx = (addr_m + 1'b1) & mask;
        addr_d[ch_sel_q] = addr_nx;
        cnt_d[ch_sel_q] = freq;
      end else begin
        cnt_d[ch_sel_q] = cnt_q[ch_sel_q] - 1'b1;
      end
      pend_d[ch_sel_q] = 1'b0;
    end
  end
`ifdef WTS_NOISE_GATE_EN
  logic [16:0] lfsr_q, lfsr_d;
  logic [4:0] ncnt_q, ncnt_d;
  always_comb begin
    lfsr_d = lfsr_q;
    ncnt_d = ncnt_q;
    if (active) begin
      ncnt_d = (ncnt_q == '0) ? reg_noise_frequency_count : ncnt_q - 1'b1;
      lfsr_d = (ncnt_q == '0) ? {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]} : lfsr_q;
    end
  end
  // gating sees the noise bit from before this cycle's shift
  assign env_g = (reg_noise_enable[ch_sel_q] && !lfsr_q[0]) ? '0 : env_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 17'h1;
      ncnt_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      ncnt_q <= ncnt_d;
    end
  end
`else
  logic unused_noise;
  assign unused_noise = ^{reg_noise_enable, reg_noise_frequency_count};
  assign env_g = env_in;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_sel_q <= '0;
      cnt_q <= '{default: '0};
      addr_q <= '{default: '0};
      pend_q <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      sram_a <= '0;
      envelope <= '0;
    end else begin
      ch_sel_q <= ch_sel_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      out_valid <= active;
      if (active) begin
        out_ch <= ch_sel_q;
        sram_a <= addr_nx;
        envelope <= env_g;
      end
    end
  end
endmodule

// File: tb/tb_wts_channel_array.sv
// tb_wts_channel_array: directed bench for wts_channel_array at default parameters
module tb_wts_channel_array;
  logic clk = 1'b0;
  logic reset, active;
  logic [4:0] address_reset, reg_noise_enable, reg_noise_frequency_count;
  logic [59:0] reg_frequency_count;
  logic [9:0] reg_wave_length;
  logic [44:0] envelope_in;
  logic out_valid;
  logic [2:0] out_ch;
  logic [6:0] sram_a;
  logic [8:0] envelope;
  int n_chk = 0, n_pass = 0;
  int exp_ch, cur;
  logic [16:0] lfsr_m;
  logic [4:0] ncnt_m;
  logic nbit;
  wts_channel_array dut (
    .clk(clk), .reset(reset), .active(active), .address_reset(address_reset),
    .reg_frequency_count(reg_frequency_count), .reg_wave_length(reg_wave_length),
    .reg_noise_enable(reg_noise_enable), .reg_noise_frequency_count(reg_noise_frequency_count),
    .envelope_in(envelope_in), .out_valid(out_valid), .out_ch(out_ch),
    .sram_a(sram_a), .envelope(envelope)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    exp_ch = 0;
    lfsr_m = 17'h1;
    ncnt_m = '0;
  endtask
  task automatic step(int gap, logic [4:0] rmask);
    repeat (gap) @(negedge clk);
    active = 1'b1;
    address_reset = rmask;
    @(negedge clk);
    active = 1'b0;
    address_reset = '0;
    cur = exp_ch;
    exp_ch = (exp_ch + 1) % 5;
    nbit = lfsr_m[0];
    if (ncnt_m == 0) begin
      ncnt_m = reg_noise_frequency_count;
      lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
    end else ncnt_m = ncnt_m - 1'b1;
  endtask
  task automatic svc(int c, int gap);
    do step(gap, '0); while (cur != c);
    check("slot", out_ch, c);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b0;
    active = 1'b0;
    address_reset = '0;
    reg_frequency_count = '0;
    reg_wave_length = '1;
    reg_noise_enable = '0;
    reg_noise_frequency_count = '0;
    for (int i = 0; i < 5; i++) envelope_in[i*9 +: 9] = 9'h40 + 9'(i);
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_ch", out_ch, 0);
    check("rst_addr", sram_a, 0);
    check("rst_env", envelope, 0);
    for (int k = 0; k < 640; k++) begin
      step(3, '0);
      check("rr_ch", out_ch, k % 5);
      check("rr_addr", sram_a, (k / 5 + 1) % 128);
      if (k < 5) begin
        check("rr_valid", out_valid, 1);
        check("rr_env", envelope, 9'h40 + k);
      end
      if (k == 7) begin
        @(negedge clk);
        check("hold_valid", out_valid, 0);
        check("hold_addr", sram_a, 2);
      end
    end
    do_reset();
    reg_frequency_count[24 +: 12] = 12'd3;
    for (int n = 1; n <= 9; n++) begin
      svc(2, 1);
      check("div3", sram_a, (n + 3) / 4);
    end
    reg_frequency_count[24 +: 12] = 12'hFFF;
    svc(1, 1);
    step(1, 5'b00100);
    check("divrst_ch", out_ch, 2);
    check("divrst_addr", sram_a, 0);
    for (int m = 1; m <= 4096; m++) begin
      svc(2, 1);
      if (m == 4095) check("divfff_hold", sram_a, 0);
      if (m == 4096) check("divfff_adv", sram_a, 1);
    end
    reg_frequency_count = '0;
    do_reset();
    repeat (40) svc(1, 1);
    check("ar_pre", sram_a, 40);
    svc(0, 1);
    @(negedge clk) address_reset = 5'b00010;
    @(negedge clk) address_reset = '0;
    step(1, '0);
    check("ar_ch", out_ch, 1);
    check("ar_early", sram_a, 0);
    svc(1, 3);
    check("ar_next", sram_a, 1);
    svc(0, 3);
    step(3, 5'b00010);
    check("ar_coin", sram_a, 0);
    svc(1, 3);
    check("ar_coin_next", sram_a, 1);
    svc(0, 3);
    @(negedge clk) address_reset = 5'b00010;
    @(negedge clk) address_reset = '0;
    @(negedge clk) address_reset = 5'b00010;
    @(negedge clk) address_reset = '0;
    step(1, '0);
    check("ar_dbl", sram_a, 0);
    svc(1, 3);
    check("ar_dbl_next", sram_a, 1);
    do_reset();
    repeat (100) svc(0, 1);
    check("wl_pre", sram_a, 100);
    reg_wave_length[1:0] = 2'd0;
    svc(0, 1);
    check("wl_cut", sram_a, 5);
    for (int k = 1; k <= 27; k++) begin
      svc(0, 1);
      check("wl_run", sram_a, (5 + k) % 32);
    end
    reg_wave_length = '1;
    do_reset();
    reg_noise_enable = 5'b01000;
    envelope_in[27 +: 9] = 9'h1FF;
    for (int j = 0; j < 17; j++) begin
      svc(3, 1);
`ifdef WTS_NOISE_GATE_EN
      check("noise_on", envelope, nbit ? 9'h1FF : 9'h000);
`else
      check("noise_on", envelope, 9'h1FF);
`endif
    end
    reg_noise_enable = '0;
    for (int j = 0; j < 5; j++) begin
      svc(3, 1);
      check("noise_off", envelope, 9'h1FF);
    end
    do_reset();
    repeat (3) step(3, '0);
    @(negedge clk);
    reset = 1'b1;
    active = 1'b1;
    address_reset = '1;
    @(negedge clk);
    reset = 1'b0;
    active = 1'b0;
    address_reset = '0;
    exp_ch = 0;
    lfsr_m = 17'h1;
    ncnt_m = '0;
    check("mid_valid", out_valid, 0);
    check("mid_ch", out_ch, 0);
    check("mid_addr", sram_a, 0);
    check("mid_env", envelope, 0);
    step(3, '0);
    check("post_ch", out_ch, 0);
    check("post_addr", sram_a, 1);
    check("post_env", envelope, 9'h40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wts_channel_array.md
# wts_channel_array

Time-multiplexed, parametrised tone/noise channel engine for the wave table sound core. It services `CH_NUM` channels round-robin, one per `active` pulse, and keeps per-channel state: frequency divider, wave address and pending address reset. Each serviced slot produces one wave-RAM address plus a noise-gated envelope, and the slot is tagged with its channel index for the downstream mixer. Envelopes are supplied externally by the per-channel ADSR generators.

## Interface
- `CH_NUM`, default 5: number of channels, range 2..16.
- `ADDR_W`, default 7: wave address width per channel, minimum 3.
- `FREQ_W`, default 12: frequency divider width.
- `ENV_W`, default 9: envelope width.

Ports (clock and reset first):
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `active` input 1: 3.579 MHz timing pulse, one `clk` wide.
- `address_reset` input `CH_NUM`: per-channel reset pulse.
- `reg_frequency_count` input `CH_NUM*FREQ_W`: flattened; channel i occupies bits [i*FREQ_W +: FREQ_W].
- `reg_wave_length` input `CH_NUM*2`: per-channel 2-bit length code.
- `reg_noise_enable` input `CH_NUM`: per-channel noise gate enable.
- `reg_noise_frequency_count` input 5: shared noise divider reload value.
- `envelope_in` input `CH_NUM*ENV_W`: flattened per-channel envelopes.
- `out_valid` output 1: one-cycle strobe marking a serviced slot.
- `out_ch` output `$clog2(CH_NUM)`: index of the serviced channel.
- `sram_a` output `ADDR_W`: wave address of the serviced channel.
- `envelope` output `ENV_W`: gated envelope of the serviced channel.

## Operation
- **Slot counter `ch_sel`.** On each `active` cycle, channel `ch_sel` is serviced, then `ch_sel` increments. It wraps from `CH_NUM-1` to 0.
- **Wave length mask.** Code 0 gives 2^(ADDR_W-2) samples, code 1 gives 2^(ADDR_W-1), codes 2 and 3 give 2^ADDR_W. The address is always ANDed with (length-1) before use and output.
- **Service of channel c, in priority order:**
  - If `pend[c]` is set: `addr[c]` <= 0, `cnt[c]` <= `reg_frequency_count[c]`, and `pend[c]` is cleared.
  - Else if `cnt[c]` == 0: `cnt[c]` <= `reg_frequency_count[c]`, and `addr[c]` <= (`addr[c]`+1) & mask.
  - Else: `cnt[c]` <= `cnt[c]`-1.
  - Result: the address advances once every (F+1) services of the channel. F=0 advances on every service.
- **Address reset.** `address_reset[i]` may arrive on any cycle and sets `pend[i]`. If it coincides with channel i's service cycle, it is applied in that same service. A reset arriving while `pend[i]` is already set is absorbed.
- **Noise.** A 17-bit LFSR with taps x^17 + x^14 + 1, seeded to 1, produces the noise bit `lfsr[0]`.
  - The 5-bit noise counter decrements on every `active` cycle, not per service.
  - At zero it reloads `reg_noise_frequency_count` and the LFSR shifts once.
- **Gating.** `envelope` = 0 when `reg_noise_enable[c]` is set and the noise bit is 0. Otherwise `envelope` = `envelope_in[c]`.
- **Output fields.** `sram_a` carries the post-update, masked address. The `envelope` output uses the noise bit value before that cycle's shift.

## Timing
- **Reset values.** On `reset`: `ch_sel`, all `cnt`, all `addr`, all `pend`, the noise counter, `out_valid`, `out_ch`, `sram_a` and `envelope` go to 0; `lfsr` goes to 17'h1.
- **Reset mid-operation.** An asserted `reset` overrides `active` and `address_reset` in the same cycle.
- **Latency.** Outputs are registered. `out_valid` is high for exactly the one cycle after each `active` cycle, with `out_ch`, `sram_a` and `envelope` valid in that cycle. Between strobes these outputs hold their last values.
- **Register sampling.** Register inputs are sampled in the `active` cycle. A frequency change therefore takes effect at the channel's next reload.
- **Wave length reduction.** A length reduction masks the address immediately on the next service output.

## Configuration
- `WTS_NOISE_GATE_EN` defined: the LFSR, noise counter and gating are built as described above.
- `WTS_NOISE_GATE_EN` undefined: none of that logic is instantiated. `envelope` = `envelope_in[c]` unconditionally, and `reg_noise_enable` and `reg_noise_frequency_count` are ignored. All other behaviour is identical.

## Test plan
- **Round-robin:** CH_NUM=5, `active` every 4 cycles, F=0 on all channels, code 3 → `out_ch` sequence 0,1,2,3,4,0; each channel's `sram_a` goes 1,2,3,… and wraps from 127 to 0.
- **Divider:** ch2 F=3 → ch2 `sram_a` increments once every 4 ch2 services; F=0xFFF → first advance on the 4096th service.
- **Address reset:** ch1 at address 40, `address_reset[1]` pulsed 2 cycles before ch1's slot → ch1 output `sram_a` = 0; with F=0 the following service gives 1. A pulse coinciding with the slot also gives 0.
- **Wave length:** ch0 at address 100, code changed 3→0 → next output is (101 & 31) = 5, and the address stays below 32 thereafter.
- **Noise gating (macro on):** noise count 0, `reg_noise_enable[3]`=1, `envelope_in[3]`=9'h1FF → `envelope` follows the LFSR bit; the first 17 bits match a reference model seeded with 1. With enable=0 the output is always 9'h1FF.
- **Reset and macro off:** `reset` asserted mid-stream → next cycle all outputs 0 and `ch_sel`=0. Rebuilt without the macro, the gating stimulus gives a constant `envelope`=9'h1FF.
